// File: rtl/ps_bitmap_ram_arbiter.sv
// Partial State Bitmap RAM arbiter: shares the single-port bitmap RAM between
// the BA controller and the host port, and runs the CSR-triggered clear sequence.
module ps_bitmap_ram_arbiter #(
  parameter int ADDR_WIDTH   = 2,
  parameter int DATA_WIDTH   = 88,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  macCoreClk,
  input  logic                  macCoreClkSoftRst,

  input  logic                  baReq,
  input  logic                  baWriteEn,
  input  logic [ADDR_WIDTH-1:0] baAddr,
  input  logic [DATA_WIDTH-1:0] baWriteData,
  output logic                  baGnt,
  output logic                  baReadValid,

  input  logic                  hostReq,
  input  logic                  hostWriteEn,
  input  logic [ADDR_WIDTH-1:0] hostAddr,
  input  logic [DATA_WIDTH-1:0] hostWriteData,
  output logic                  hostGnt,
  output logic                  hostReadValid,

  input  logic                  baPSBitmapReset,
  output logic                  baPSBitmapResetIn,
  output logic                  baPSBitmapResetInValid,
  output logic                  clearBusy,

  input  logic [DATA_WIDTH-1:0] psBitmapReadData,
  output logic                  psBitmapEn,
  output logic                  psBitmapWriteEn,
  output logic [ADDR_WIDTH-1:0] psBitmapAddr,
  output logic [DATA_WIDTH-1:0] psBitmapWriteData
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [3:0]            STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clrAddr_q, clrAddr_d;
  logic [3:0]              starveCnt_q, starveCnt_d;
  logic                    rstPrev_q;
  logic                    baReadValid_q;
  logic                    hostReadValid_q;
  logic                    resetInValid_q;

  logic                    clrStart;
  logic                    hostWin;
  logic                    baWin;
  logic                    ramEn;
  logic                    ramWe;
  logic [ADDR_WIDTH-1:0]   ramAddr;
  logic [DATA_WIDTH-1:0]   ramWdata;

  always_comb begin
    state_d     = state_q;
    clrAddr_d   = clrAddr_q;
    starveCnt_d = starveCnt_q;
    clrStart    = 1'b0;
    hostWin     = 1'b0;
    baWin       = 1'b0;
    ramEn       = 1'b0;
    ramWe       = 1'b0;
    ramAddr     = '0;
    ramWdata    = '0;

    unique case (state_q)
      ARB: begin
        // A CSR level already high when leaving reset looks like a fresh edge.
        clrStart = baPSBitmapReset & ~rstPrev_q;
        if (clrStart) begin
          state_d   = CLEAR;
          clrAddr_d = '0;
        end else begin
          hostWin = hostReq & (~baReq | (starveCnt_q == STARVE_MAX));
          baWin   = baReq & ~hostWin;
        end

        if (hostWin || !hostReq) begin
          starveCnt_d = '0;
        end else if (baWin && (starveCnt_q != STARVE_MAX)) begin
          starveCnt_d = starveCnt_q + 4'd1;
        end

        if (hostWin) begin
          ramEn    = 1'b1;
          ramWe    = hostWriteEn;
          ramAddr  = hostAddr;
          ramWdata = hostWriteData;
        end else if (baWin) begin
          ramEn    = 1'b1;
          ramWe    = baWriteEn;
          ramAddr  = baAddr;
          ramWdata = baWriteData;
        end
      end

      CLEAR: begin
        ramEn     = 1'b1;
        ramWe     = 1'b1;
        ramAddr   = clrAddr_q;
        clrAddr_d = clrAddr_q + 1'b1;
        if (clrAddr_q == LAST_ADDR) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = ARB;
      end

      default: begin
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge macCoreClk) begin
    if (macCoreClkSoftRst) begin
      state_q         <= ARB;
      clrAddr_q       <= '0;
      starveCnt_q     <= '0;
      rstPrev_q       <= 1'b0;
      baReadValid_q   <= 1'b0;
      hostReadValid_q <= 1'b0;
      resetInValid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      clrAddr_q       <= clrAddr_d;
      starveCnt_q     <= starveCnt_d;
      rstPrev_q       <= baPSBitmapReset;
      baReadValid_q   <= baWin & ~baWriteEn;
      hostReadValid_q <= hostWin & ~hostWriteEn;
      resetInValid_q  <= (state_d == DONE);
    end
  end

  // Everything combinational is held quiet while reset is asserted.
  assign baGnt                  = baWin & ~macCoreClkSoftRst;
  assign hostGnt                = hostWin & ~macCoreClkSoftRst;
  assign psBitmapEn             = ramEn & ~macCoreClkSoftRst;
  assign psBitmapWriteEn        = ramWe & ~macCoreClkSoftRst;
  assign psBitmapAddr           = macCoreClkSoftRst ? '0 : ramAddr;
  assign psBitmapWriteData      = macCoreClkSoftRst ? '0 : ramWdata;
  assign clearBusy              = (state_q != ARB) & ~macCoreClkSoftRst;

  assign baReadValid            = baReadValid_q;
  assign hostReadValid          = hostReadValid_q;
  assign baPSBitmapResetInValid = resetInValid_q;
  assign baPSBitmapResetIn      = 1'b0;

endmodule

// File: tb/tb_ps_bitmap_ram_arbiter.sv
// Self-checking bench for ps_bitmap_ram_arbiter with a behavioural 4x88 RAM
// and a read-return scoreboard.
module tb_ps_bitmap_ram_arbiter;

  localparam int AW = 2;
  localparam int DW = 88;

  logic          macCoreClk = 1'b0;
  logic          macCoreClkSoftRst;
  logic          baReq, baWriteEn, baGnt, baReadValid;
  logic [AW-1:0] baAddr;
  logic [DW-1:0] baWriteData;
  logic          hostReq, hostWriteEn, hostGnt, hostReadValid;
  logic [AW-1:0] hostAddr;
  logic [DW-1:0] hostWriteData;
  logic          baPSBitmapReset, baPSBitmapResetIn, baPSBitmapResetInValid, clearBusy;
  logic [DW-1:0] psBitmapReadData;
  logic          psBitmapEn, psBitmapWriteEn;
  logic [AW-1:0] psBitmapAddr;
  logic [DW-1:0] psBitmapWriteData;

  typedef struct {
    logic          isHost;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           expQ[$];
  logic [DW-1:0] refMem [4];
  logic [DW-1:0] ramMem [4];
  int            checkCnt = 0;
  int            passCnt  = 0;

  ps_bitmap_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .macCoreClk(macCoreClk), .macCoreClkSoftRst(macCoreClkSoftRst),
    .baReq(baReq), .baWriteEn(baWriteEn), .baAddr(baAddr), .baWriteData(baWriteData),
    .baGnt(baGnt), .baReadValid(baReadValid),
    .hostReq(hostReq), .hostWriteEn(hostWriteEn), .hostAddr(hostAddr),
    .hostWriteData(hostWriteData), .hostGnt(hostGnt), .hostReadValid(hostReadValid),
    .baPSBitmapReset(baPSBitmapReset), .baPSBitmapResetIn(baPSBitmapResetIn),
    .baPSBitmapResetInValid(baPSBitmapResetInValid), .clearBusy(clearBusy),
    .psBitmapReadData(psBitmapReadData), .psBitmapEn(psBitmapEn),
    .psBitmapWriteEn(psBitmapWriteEn), .psBitmapAddr(psBitmapAddr),
    .psBitmapWriteData(psBitmapWriteData)
  );

  always #5 macCoreClk = ~macCoreClk;

  // Behavioural single-port SRAM macro with one-cycle read latency.
  always @(posedge macCoreClk) begin
    if (psBitmapEn) begin
      if (psBitmapWriteEn) ramMem[psBitmapAddr] <= psBitmapWriteData;
      else                 psBitmapReadData     <= ramMem[psBitmapAddr];
    end
  end

  task automatic tick();
    @(posedge macCoreClk);
    @(negedge macCoreClk);
  endtask

  task automatic idleInputs();
    baReq = 1'b0; baWriteEn = 1'b0; baAddr = '0; baWriteData = '0;
    hostReq = 1'b0; hostWriteEn = 1'b0; hostAddr = '0; hostWriteData = '0;
  endtask

  task automatic test_reset();
    macCoreClkSoftRst = 1'b1;
    baPSBitmapReset = 1'b0;
    baReq = 1'b1; baWriteEn = 1'b1; baAddr = 2'd3; baWriteData = '1;
    hostReq = 1'b1; hostWriteEn = 1'b1; hostAddr = 2'd2; hostWriteData = '1;
    @(negedge macCoreClk);
    tick();
    #1;
    checkCnt++;
    if ({baGnt, hostGnt, psBitmapEn, psBitmapWriteEn} !== 4'b0000)
      $display("[TB] FAIL reset_gnt_en: gnt=%b%b en=%b we=%b, expected all 0", baGnt, hostGnt, psBitmapEn, psBitmapWriteEn);
    else passCnt++;
    checkCnt++;
    if (psBitmapAddr !== 2'd0 || psBitmapWriteData !== '0)
      $display("[TB] FAIL reset_addr_data: addr=%0d wdata=%h, expected 0 0", psBitmapAddr, psBitmapWriteData);
    else passCnt++;
    checkCnt++;
    if ({baReadValid, hostReadValid, baPSBitmapResetInValid, baPSBitmapResetIn, clearBusy} !== 5'b00000)
      $display("[TB] FAIL reset_regs: baRV=%b hostRV=%b strobe=%b resetIn=%b busy=%b, expected all 0",
               baReadValid, hostReadValid, baPSBitmapResetInValid, baPSBitmapResetIn, clearBusy);
    else passCnt++;
    idleInputs();
    macCoreClkSoftRst = 1'b0;
    tick();
    #1;
    checkCnt++;
    if ({baGnt, hostGnt, psBitmapEn, baReadValid, hostReadValid, baPSBitmapResetInValid, clearBusy} !== 7'b0)
      $display("[TB] FAIL reset_idle: gnt=%b%b en=%b rv=%b%b strobe=%b busy=%b, expected all 0",
               baGnt, hostGnt, psBitmapEn, baReadValid, hostReadValid, baPSBitmapResetInValid, clearBusy);
    else passCnt++;
    tick();
  endtask

  task automatic test_write_readback();
    rd_t           e;
    logic          expBa, expHost, expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData, pat;
    for (int i = 0; i < 7; i++) begin
      idleInputs();
      expBa = 1'b0; expHost = 1'b0; expWe = 1'b0; expAddr = '0; expData = '0;
      pat = {11{8'(8'h11 * (i + 1))}};
      case (i)
        0, 1, 2: begin
          baReq = 1'b1; baWriteEn = 1'b1; baAddr = 2'(i); baWriteData = pat;
          expBa = 1'b1; expWe = 1'b1; expAddr = 2'(i); expData = pat;
        end
        3: begin
          hostReq = 1'b1; hostWriteEn = 1'b1; hostAddr = 2'd3; hostWriteData = {11{8'hA5}};
          expHost = 1'b1; expWe = 1'b1; expAddr = 2'd3; expData = {11{8'hA5}};
        end
        4: begin
          hostReq = 1'b1; hostAddr = 2'd3;
          expHost = 1'b1; expAddr = 2'd3;
        end
        5: begin
          baReq = 1'b1; baAddr = 2'd0;
          expBa = 1'b1; expAddr = 2'd0;
        end
        default: ;
      endcase
      #1;
      checkCnt++;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        if ((e.isHost ? hostReadValid : baReadValid) !== 1'b1 || (e.isHost ? baReadValid : hostReadValid) !== 1'b0 || psBitmapReadData !== e.data)
          $display("[TB] FAIL wr_rd_return[%0d]: baRV=%b hostRV=%b data=%h, expected %s valid data=%h",
                   i, baReadValid, hostReadValid, psBitmapReadData, e.isHost ? "host" : "ba", e.data);
        else passCnt++;
      end else if (baReadValid !== 1'b0 || hostReadValid !== 1'b0)
        $display("[TB] FAIL wr_rd_noreturn[%0d]: baRV=%b hostRV=%b, expected 0 0", i, baReadValid, hostReadValid);
      else passCnt++;
      checkCnt++;
      if ({baGnt, hostGnt, psBitmapEn, psBitmapWriteEn} !== {expBa, expHost, expBa | expHost, expWe} ||
          psBitmapAddr !== expAddr || psBitmapWriteData !== expData)
        $display("[TB] FAIL wr_rd_pins[%0d]: gnt=%b%b en=%b we=%b addr=%0d wdata=%h, expected %b%b %b %b %0d %h",
                 i, baGnt, hostGnt, psBitmapEn, psBitmapWriteEn, psBitmapAddr, psBitmapWriteData,
                 expBa, expHost, expBa | expHost, expWe, expAddr, expData);
      else passCnt++;
      if (expWe) refMem[expAddr] = expData;
      else if (expBa || expHost) expQ.push_back('{isHost: expHost, data: refMem[expAddr]});
      tick();
    end
  endtask

  task automatic test_read_no_contention();
    rd_t e;
    for (int i = 0; i < 3; i++) begin
      idleInputs();
      if (i == 0) begin
        baReq = 1'b1; baAddr = 2'd2;
      end
      #1;
      checkCnt++;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        if ((e.isHost ? hostReadValid : baReadValid) !== 1'b1 || (e.isHost ? baReadValid : hostReadValid) !== 1'b0 || psBitmapReadData !== e.data)
          $display("[TB] FAIL rd_return[%0d]: baRV=%b hostRV=%b data=%h, expected %s valid data=%h",
                   i, baReadValid, hostReadValid, psBitmapReadData, e.isHost ? "host" : "ba", e.data);
        else passCnt++;
      end else if (baReadValid !== 1'b0 || hostReadValid !== 1'b0)
        $display("[TB] FAIL rd_noreturn[%0d]: baRV=%b hostRV=%b, expected 0 0", i, baReadValid, hostReadValid);
      else passCnt++;
      checkCnt++;
      if (i == 0 && ({baGnt, hostGnt, psBitmapEn, psBitmapWriteEn} !== 4'b1010 || psBitmapAddr !== 2'd2))
        $display("[TB] FAIL rd_pins: gnt=%b%b en=%b we=%b addr=%0d, expected 10 1 0 2",
                 baGnt, hostGnt, psBitmapEn, psBitmapWriteEn, psBitmapAddr);
      else if (i != 0 && {baGnt, hostGnt, psBitmapEn} !== 3'b000)
        $display("[TB] FAIL rd_idle[%0d]: gnt=%b%b en=%b, expected 00 0", i, baGnt, hostGnt, psBitmapEn);
      else passCnt++;
      if (i == 0) expQ.push_back('{isHost: 1'b0, data: refMem[2]});
      tick();
    end
  endtask

  task automatic test_contention();
    rd_t  e;
    logic expHost;
    baReq = 1'b1; baWriteEn = 1'b0; baAddr = 2'd0; baWriteData = '0;
    hostReq = 1'b1; hostWriteEn = 1'b0; hostAddr = 2'd1; hostWriteData = '0;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) idleInputs();
      #1;
      checkCnt++;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        if ((e.isHost ? hostReadValid : baReadValid) !== 1'b1 || (e.isHost ? baReadValid : hostReadValid) !== 1'b0 || psBitmapReadData !== e.data)
          $display("[TB] FAIL starve_return[%0d]: baRV=%b hostRV=%b data=%h, expected %s valid data=%h",
                   i, baReadValid, hostReadValid, psBitmapReadData, e.isHost ? "host" : "ba", e.data);
        else passCnt++;
      end else if (baReadValid !== 1'b0 || hostReadValid !== 1'b0)
        $display("[TB] FAIL starve_noreturn[%0d]: baRV=%b hostRV=%b, expected 0 0", i, baReadValid, hostReadValid);
      else passCnt++;
      if (i < 10) begin
        expHost = ((i % 5) == 4);
        checkCnt++;
        if (hostGnt !== expHost || baGnt !== !expHost || psBitmapEn !== 1'b1 || psBitmapAddr !== (expHost ? 2'd1 : 2'd0))
          $display("[TB] FAIL starve_gnt[%0d]: baGnt=%b hostGnt=%b en=%b addr=%0d, expected %b %b 1 %0d",
                   i, baGnt, hostGnt, psBitmapEn, psBitmapAddr, !expHost, expHost, expHost ? 1 : 0);
        else passCnt++;
        expQ.push_back('{isHost: expHost, data: refMem[expHost ? 1 : 0]});
      end
      tick();
    end
  endtask

  task automatic test_clear();
    rd_t           e;
    logic          expEn, expWe, expBa, expStrobe, expBusy;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    for (int i = 0; i < 8; i++) begin
      idleInputs();
      baPSBitmapReset = (i <= 5);
      if (i < 7) begin
        baReq = 1'b1; baAddr = 2'd2; baWriteData = '1;
      end
      expWe     = (i >= 1 && i <= 4);
      expBa     = (i == 6);
      expEn     = expWe | expBa;
      expAddr   = expWe ? 2'(i - 1) : (expBa ? 2'd2 : 2'd0);
      expData   = expBa ? '1 : '0;
      expStrobe = (i == 5);
      expBusy   = (i >= 1 && i <= 5);
      #1;
      checkCnt++;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        if ((e.isHost ? hostReadValid : baReadValid) !== 1'b1 || (e.isHost ? baReadValid : hostReadValid) !== 1'b0 || psBitmapReadData !== e.data)
          $display("[TB] FAIL clr_return[%0d]: baRV=%b hostRV=%b data=%h, expected %s valid data=%h",
                   i, baReadValid, hostReadValid, psBitmapReadData, e.isHost ? "host" : "ba", e.data);
        else passCnt++;
      end else if (baReadValid !== 1'b0 || hostReadValid !== 1'b0)
        $display("[TB] FAIL clr_noreturn[%0d]: baRV=%b hostRV=%b, expected 0 0", i, baReadValid, hostReadValid);
      else passCnt++;
      checkCnt++;
      if ({baGnt, hostGnt, psBitmapEn, psBitmapWriteEn} !== {expBa, 1'b0, expEn, expWe} ||
          psBitmapAddr !== expAddr || psBitmapWriteData !== expData)
        $display("[TB] FAIL clr_pins[%0d]: gnt=%b%b en=%b we=%b addr=%0d wdata=%h, expected %b0 %b %b %0d %h",
                 i, baGnt, hostGnt, psBitmapEn, psBitmapWriteEn, psBitmapAddr, psBitmapWriteData,
                 expBa, expEn, expWe, expAddr, expData);
      else passCnt++;
      checkCnt++;
      if ({baPSBitmapResetInValid, baPSBitmapResetIn, clearBusy} !== {expStrobe, 1'b0, expBusy})
        $display("[TB] FAIL clr_status[%0d]: strobe=%b resetIn=%b busy=%b, expected %b 0 %b",
                 i, baPSBitmapResetInValid, baPSBitmapResetIn, clearBusy, expStrobe, expBusy);
      else passCnt++;
      if (expWe) refMem[expAddr] = '0;
      if (expBa) expQ.push_back('{isHost: 1'b0, data: refMem[2]});
      tick();
    end
  endtask

  task automatic test_read_clear_overlap();
    rd_t           e;
    logic          expEn, expWe, expBa, expHost, expStrobe, expBusy;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData, pat;
    pat = 88'h0123_4567_89AB_CDEF_FEDC_BA;
    for (int i = 0; i < 9; i++) begin
      idleInputs();
      baPSBitmapReset = (i >= 2 && i <= 7);
      if (i == 0) begin
        hostReq = 1'b1; hostWriteEn = 1'b1; hostAddr = 2'd1; hostWriteData = pat;
      end
      if (i == 1) begin
        baReq = 1'b1; baAddr = 2'd1;
      end
      expHost   = (i == 0);
      expBa     = (i == 1);
      expWe     = (i == 0) || (i >= 3 && i <= 6);
      expEn     = expWe | expBa;
      expAddr   = (i >= 3 && i <= 6) ? 2'(i - 3) : (expEn ? 2'd1 : 2'd0);
      expData   = expHost ? pat : '0;
      expStrobe = (i == 7);
      expBusy   = (i >= 3 && i <= 7);
      #1;
      checkCnt++;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        if ((e.isHost ? hostReadValid : baReadValid) !== 1'b1 || (e.isHost ? baReadValid : hostReadValid) !== 1'b0 || psBitmapReadData !== e.data)
          $display("[TB] FAIL ovl_return[%0d]: baRV=%b hostRV=%b data=%h, expected %s valid data=%h",
                   i, baReadValid, hostReadValid, psBitmapReadData, e.isHost ? "host" : "ba", e.data);
        else passCnt++;
      end else if (baReadValid !== 1'b0 || hostReadValid !== 1'b0)
        $display("[TB] FAIL ovl_noreturn[%0d]: baRV=%b hostRV=%b, expected 0 0", i, baReadValid, hostReadValid);
      else passCnt++;
      checkCnt++;
      if ({baGnt, hostGnt, psBitmapEn, psBitmapWriteEn} !== {expBa, expHost, expEn, expWe} ||
          psBitmapAddr !== expAddr || psBitmapWriteData !== expData)
        $display("[TB] FAIL ovl_pins[%0d]: gnt=%b%b en=%b we=%b addr=%0d wdata=%h, expected %b%b %b %b %0d %h",
                 i, baGnt, hostGnt, psBitmapEn, psBitmapWriteEn, psBitmapAddr, psBitmapWriteData,
                 expBa, expHost, expEn, expWe, expAddr, expData);
      else passCnt++;
      checkCnt++;
      if ({baPSBitmapResetInValid, clearBusy} !== {expStrobe, expBusy})
        $display("[TB] FAIL ovl_status[%0d]: strobe=%b busy=%b, expected %b %b",
                 i, baPSBitmapResetInValid, clearBusy, expStrobe, expBusy);
      else passCnt++;
      if (expWe) refMem[expAddr] = expData;
      if (expBa) expQ.push_back('{isHost: 1'b0, data: refMem[1]});
      tick();
    end
  endtask

  task automatic test_reset_mid_clear();
    rd_t           e;
    logic          expEn, expStrobe, expBusy;
    logic [AW-1:0] expAddr;
    int            strobeCnt;
    strobeCnt = 0;
    for (int i = 0; i < 10; i++) begin
      idleInputs();
      baPSBitmapReset   = (i <= 8);
      macCoreClkSoftRst = (i == 2);
      expEn     = (i == 1) || (i >= 4 && i <= 7);
      expAddr   = (i >= 4 && i <= 7) ? 2'(i - 4) : 2'd0;
      expStrobe = (i == 8);
      expBusy   = (i == 1) || (i >= 4 && i <= 8);
      #1;
      checkCnt++;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        if ((e.isHost ? hostReadValid : baReadValid) !== 1'b1 || psBitmapReadData !== e.data)
          $display("[TB] FAIL rmc_return[%0d]: baRV=%b hostRV=%b data=%h, expected %s valid data=%h",
                   i, baReadValid, hostReadValid, psBitmapReadData, e.isHost ? "host" : "ba", e.data);
        else passCnt++;
      end else if (baReadValid !== 1'b0 || hostReadValid !== 1'b0)
        $display("[TB] FAIL rmc_noreturn[%0d]: baRV=%b hostRV=%b, expected 0 0", i, baReadValid, hostReadValid);
      else passCnt++;
      checkCnt++;
      if ({baGnt, hostGnt, psBitmapEn, psBitmapWriteEn} !== {2'b00, expEn, expEn} ||
          psBitmapAddr !== expAddr || psBitmapWriteData !== '0)
        $display("[TB] FAIL rmc_pins[%0d]: gnt=%b%b en=%b we=%b addr=%0d wdata=%h, expected 00 %b %b %0d 0",
                 i, baGnt, hostGnt, psBitmapEn, psBitmapWriteEn, psBitmapAddr, psBitmapWriteData,
                 expEn, expEn, expAddr);
      else passCnt++;
      checkCnt++;
      if ({baPSBitmapResetInValid, baPSBitmapResetIn, clearBusy} !== {expStrobe, 1'b0, expBusy})
        $display("[TB] FAIL rmc_status[%0d]: strobe=%b resetIn=%b busy=%b, expected %b 0 %b",
                 i, baPSBitmapResetInValid, baPSBitmapResetIn, clearBusy, expStrobe, expBusy);
      else passCnt++;
      if (baPSBitmapResetInValid === 1'b1) strobeCnt++;
      if (expEn) refMem[expAddr] = '0;
      tick();
    end
    macCoreClkSoftRst = 1'b0;
    checkCnt++;
    if (strobeCnt != 1)
      $display("[TB] FAIL rmc_strobe_count: saw %0d strobes, expected 1", strobeCnt);
    else passCnt++;
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_write_readback();
    test_read_no_contention();
    test_contention();
    test_clear();
    test_read_clear_overlap();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/ps_bitmap_ram_arbiter.md
Name: ps_bitmap_ram_arbiter

Overview:
- Arbitrates and sequences the single-port 4x88 Partial State Bitmap RAM between two requesters: the BA controller FSM (RX scoreboard path) and a host/debug access port.
- Also owns the bitmap-reset sequencer. When the CSR sets baPSBitmapReset, the block writes zeros to every RAM entry, then clears the CSR bit through baPSBitmapResetIn/baPSBitmapResetInValid.
- Sits between the BA controller and the PS Bitmap SRAM macro; all RAM pins come from this block only.

Parameters:
ADDR_WIDTH, 2, RAM address width; depth = 2**ADDR_WIDTH entries.
DATA_WIDTH, 88, RAM word width (64-bit bitmap + 12-bit SSN + 12-bit tag/flags).
STARVE_LIMIT, 4, consecutive host-losing cycles after which the host is granted once ahead of BA (range 1..15).

Ports:
macCoreClk  in  1  MAC core clock; every register is clocked on its rising edge.
macCoreClkSoftRst  in  1  synchronous reset, active-high.
baReq  in  1  BA controller access request (one access per granted cycle).
baWriteEn  in  1  1 = write, 0 = read; qualified by baReq.
baAddr  in  ADDR_WIDTH  BA access address.
baWriteData  in  DATA_WIDTH  BA write data.
baGnt  out  1  BA access accepted this cycle (combinational).
baReadValid  out  1  psBitmapReadData holds BA read result (registered).
hostReq  in  1  host access request.
hostWriteEn  in  1  host write enable.
hostAddr  in  ADDR_WIDTH  host address.
hostWriteData  in  DATA_WIDTH  host write data.
hostGnt  out  1  host access accepted this cycle (combinational).
hostReadValid  out  1  psBitmapReadData holds host read result (registered).
baPSBitmapReset  in  1  CSR bitmap-reset request (level, held until cleared).
baPSBitmapResetIn  out  1  value written back to CSR bit; constant 0.
baPSBitmapResetInValid  out  1  one-cycle strobe that clears the CSR bit.
clearBusy  out  1  high while the clear sequence owns the RAM.
psBitmapReadData  in  DATA_WIDTH  RAM read data; valid 1 cycle after a read enable.
psBitmapEn  out  1  RAM enable.
psBitmapWriteEn  out  1  RAM write enable.
psBitmapAddr  out  ADDR_WIDTH  RAM address.
psBitmapWriteData  out  DATA_WIDTH  RAM write data.

Behaviour:
Reset and registers:
- Reset (macCoreClkSoftRst=1 at a clock edge) sets: state=ARB, clrAddr=0, starveCnt=0, rstPrev=0, all registered outputs 0.
- While reset is high, all combinational outputs are forced to 0: grants, psBitmapEn, psBitmapWriteEn, psBitmapAddr, psBitmapWriteData.
- baPSBitmapResetIn is always 0.

States:
- ARB: arbitration.
- CLEAR: sequencer walks the RAM.
- DONE: acknowledge to CSR.

Clear start:
- clrStart = baPSBitmapReset & ~rstPrev & (state==ARB). rstPrev is registered from baPSBitmapReset every cycle.
- A level still high after reset therefore counts as a rising edge and starts a clear.

ARB state:
- If clrStart: no grant this cycle; next state = CLEAR, clrAddr=0.
- Otherwise the host wins if hostReq & (~baReq | starveCnt==STARVE_LIMIT); else BA wins if baReq.
- At most one grant per cycle.
- The granted requester's en/we/addr/wdata drive the RAM combinationally in the same cycle. With no grant, psBitmapEn=0 and the other RAM outputs are 0.
- starveCnt: 0 if hostGnt or ~hostReq; +1 (saturating at STARVE_LIMIT) if hostReq & baGnt.

CLEAR state:
- psBitmapEn=1, psBitmapWriteEn=1, psBitmapAddr=clrAddr, psBitmapWriteData=0.
- clrAddr increments each cycle; at clrAddr=depth-1 the next state is DONE.
- No grants; starveCnt holds. clearBusy=1 during CLEAR and DONE.

DONE state:
- Registered output baPSBitmapResetInValid=1 for exactly one cycle, then state returns to ARB.
- No grants during DONE.

Read return:
- baReadValid(t+1) = baGnt(t) & ~baWriteEn(t); hostReadValid likewise.
- Read latency is exactly 1 cycle.
- Valid flags are unaffected by a clear that starts in the cycle after the read.

Other rules:
- Writes produce no valid.
- Requesters hold req/addr/data until they are granted.
- Reset during CLEAR or DONE: the sequence is aborted with no strobe. Because rstPrev=0, a still-high baPSBitmapReset restarts the clear from address 0.
- Clear occupancy is fixed at depth+1 cycles (CLEAR + DONE) after the start cycle.

Test Plan:
- Reads with no contention: baReq read addr 2 at t0 -> baGnt=1 at t0; psBitmapEn=1, WriteEn=0, Addr=2; baReadValid=1 at t1 only; hostReadValid=0.
- Contention and starvation, STARVE_LIMIT=4: baReq and hostReq held high -> BA is granted 4 cycles, the host is granted on the 5th; starveCnt returns to 0; pattern repeats BA x4 / host x1.
- Clear sequence: baPSBitmapReset rises at t0 -> no grant at t0; writes of 88'h0 to addresses 0,1,2,3 at t1..t4; baPSBitmapResetInValid=1 at t5 with baPSBitmapResetIn=0; grants resume at t6; baReq held throughout is granted at t6.
- Read/clear overlap: BA read addr 1 granted at t0 and baPSBitmapReset rises at t1 -> baReadValid=1 at t1; clear writes at t2..t5; strobe at t6.
- Reset mid-clear: assert macCoreClkSoftRst at the t2 edge with baPSBitmapReset held -> no strobe; after reset deassert, the clear restarts at address 0 and then strobes once.
- Write then read-back by the host: write 88'hA5..A5 to addr 3, then read addr 3 -> hostReadValid=1 one cycle after the read grant; the RAM model returns 88'hA5..A5.
